// File: rtl/sprite_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter_if
//   Bundle between the sprite engines, the shared sprite ROM and the arbiter.
//   The "master" side is the environment: the engines that raise req/addr and
//   the ROM that returns rom_data. The "slave" side is the arbiter itself.
//
//   req       per-engine request, held high for a whole sprite run
//   addr      packed per-engine ROM address, slice i = addr[i*ADDRW +: ADDRW]
//   grant     one-hot grant back to the engines
//   rom_addr  address presented to the shared ROM
//   rom_en    ROM read enable
//   rom_data  ROM read data, valid LAT cycles after rom_en
//   rd_data   returned pixel data (0 when nothing is valid)
//   rd_valid  one-hot marker of which engine rd_data belongs to
// ---------------------------------------------------------------------------
interface sprite_rom_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int ADDRW     = 10,
  parameter int COLR_BITS = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*ADDRW-1:0] addr;
  logic [NREQ-1:0]       grant;
  logic [ADDRW-1:0]      rom_addr;
  logic                  rom_en;
  logic [COLR_BITS-1:0]  rom_data;
  logic [COLR_BITS-1:0]  rd_data;
  logic [NREQ-1:0]       rd_valid;

  modport master (
    output req, addr, rom_data,
    input  grant, rom_addr, rom_en, rd_data, rd_valid
  );

  modport slave (
    input  req, addr, rom_data,
    output grant, rom_addr, rom_en, rd_data, rd_valid
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM read port among NREQ sprite engines.
//   An engine that wins arbitration keeps the ROM for its whole run; on release
//   the next requester (round-robin from the releasing owner) is granted in the
//   same cycle. Read data comes back LAT cycles later tagged with a one-hot
//   rd_valid. Denied-request cycles are counted per frame for debug.
//
//   clk           pixel clock
//   rst           asynchronous active-high reset
//   frame         start-of-frame pulse, clears conflict and conflict_cnt
//   bus           engine/ROM bundle (slave modport)
//   owner         index of the current or last owner
//   busy          ROM currently held or granted this cycle
//   conflict      sticky "some request was denied" flag
//   conflict_cnt  saturating count of denied-request cycles
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDRW     = 10,
  parameter int COLR_BITS = 4,
  parameter int LAT       = 1,
  parameter int CNTW      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame,
  sprite_rom_arbiter_if.slave      bus,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic                     conflict,
  output logic [CNTW-1:0]          conflict_cnt
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  conflict_q, conflict_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]       pipe_q [LAT];
  logic [NREQ-1:0]       pipe_d [LAT];

  logic                  holding, releasing, arb_en, found, sel_valid, deny;
  logic [OW-1:0]         arb_base, winner, idx, sel;
  logic [NREQ-1:0]       grant_c;
  logic [ADDRW-1:0]      rom_addr_c;
  logic [COLR_BITS-1:0]  rd_data_c;

  // Increment modulo NREQ; NREQ need not be a power of two.
  function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] v);
    return (int'(v) == NREQ - 1) ? '0 : v + OW'(1);
  endfunction

  // Round-robin search. On a release the scan starts just past the releasing
  // owner, which is exactly the pointer value being written this cycle, so the
  // handoff needs no idle bubble.
  always_comb begin : arbitrate
    // NOTE: every comb output gets a default first so no path infers a latch.
    holding   = (state_q == LOCKED) && bus.req[owner_q];
    releasing = (state_q == LOCKED) && !bus.req[owner_q];
    arb_en    = (state_q == IDLE) || releasing;
    arb_base  = releasing ? inc_mod(owner_q) : rr_ptr_q;
    found     = 1'b0;
    winner    = '0;
    idx       = arb_base;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = inc_mod(idx);
    end
  end

  // Next-state logic.
  always_comb begin : next_state
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (releasing) rr_ptr_d = arb_base;
    if (arb_en) begin
      if (found) begin
        state_d = LOCKED;
        owner_d = winner;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Output logic. rst gates the grant directly so grant/rom_en drop the moment
  // reset asserts, even while an engine is still requesting.
  always_comb begin : outputs
    sel        = holding ? owner_q : winner;
    sel_valid  = !rst && (holding || (arb_en && found));
    grant_c    = '0;
    rom_addr_c = '0;
    if (sel_valid) begin
      grant_c[sel] = 1'b1;
      rom_addr_c   = bus.addr[int'(sel)*ADDRW +: ADDRW];
    end
  end

  // Conflict statistics and return pipeline. frame wins over an increment.
  always_comb begin : stats_pipe
    deny       = |(bus.req & ~grant_c);
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    if (frame) begin
      cnt_d      = '0;
      conflict_d = 1'b0;
    end else if (deny) begin
      conflict_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end
    pipe_d[0] = grant_c;
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      // NOTE: the grant pipeline is reset too; a stale stage would raise a
      // spurious rd_valid right after reset.
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      pipe_q     <= pipe_d;
    end
  end

  assign rd_data_c     = (|pipe_q[LAT-1]) ? bus.rom_data : '0;

  assign bus.grant     = grant_c;
  assign bus.rom_en    = |grant_c;
  assign bus.rom_addr  = rom_addr_c;
  assign bus.rd_valid  = pipe_q[LAT-1];
  assign bus.rd_data   = rd_data_c;
  assign owner         = owner_q;
  assign busy          = (state_q == LOCKED) || (|grant_c);
  assign conflict      = conflict_q;
  assign conflict_cnt  = cnt_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//   Two arbiters share one stimulus stream: dut_a (LAT=1, CNTW=16) and
//   dut_b (LAT=3, CNTW=4). A behavioural model (integer owner/pointer, modulo
//   arithmetic, queues of past grants) predicts every output of both.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int CB = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              frame;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   addr;

  logic [1:0]        owner_a, owner_b;
  logic              busy_a, busy_b, conflict_a, conflict_b;
  logic [15:0]       cnt_a;
  logic [3:0]        cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.NREQ(N), .ADDRW(AW), .COLR_BITS(CB)) if_a ();
  sprite_rom_arbiter_if #(.NREQ(N), .ADDRW(AW), .COLR_BITS(CB)) if_b ();

  assign if_a.req  = req;
  assign if_a.addr = addr;
  assign if_b.req  = req;
  assign if_b.addr = addr;

  sprite_rom_arbiter #(.NREQ(N), .ADDRW(AW), .COLR_BITS(CB), .LAT(1), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .frame(frame), .bus(if_a.slave),
    .owner(owner_a), .busy(busy_a), .conflict(conflict_a), .conflict_cnt(cnt_a)
  );

  sprite_rom_arbiter #(.NREQ(N), .ADDRW(AW), .COLR_BITS(CB), .LAT(3), .CNTW(4)) dut_b (
    .clk(clk), .rst(rst), .frame(frame), .bus(if_b.slave),
    .owner(owner_b), .busy(busy_b), .conflict(conflict_b), .conflict_cnt(cnt_b)
  );

  // ROM contents: a fixed function of the address.
  function automatic logic [CB-1:0] rom_word(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
  endfunction

  // Synchronous ROMs with latency 1 and 3.
  logic [CB-1:0] rp_a [1];
  logic [CB-1:0] rp_b [3];
  always @(posedge clk) begin
    rp_a[0] <= rom_word(if_a.rom_addr);
    rp_b[0] <= rom_word(if_b.rom_addr);
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end
  assign if_a.rom_data = rp_a[0];
  assign if_b.rom_data = rp_b[2];

  // ---------------- reference model ----------------
  bit              m_locked;
  int              m_owner, m_ptr, m_cnt_a, m_cnt_b;
  bit              m_conf;
  logic [N-1:0]    hist_g [$];
  logic [AW-1:0]   hist_a [$];

  logic [N-1:0]    obs_grant_a, obs_rdv_a, obs_rdv_b;
  logic [15:0]     obs_cnt_a;
  logic [3:0]      obs_cnt_b;
  logic            obs_conf_a, obs_conf_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0;
    m_cnt_a = 0; m_cnt_b = 0; m_conf = 0;
    hist_g = {}; hist_a = {};
    for (int i = 0; i < 4; i++) begin
      hist_g.push_back('0);
      hist_a.push_back('0);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, update the
  // model for the coming rising edge.
  task automatic step(input logic [N-1:0] r, input logic f, input logic [N*AW-1:0] av);
    int            gi;
    bit            hold, deny;
    logic [N-1:0]  eg, ev_a, ev_b;
    logic [AW-1:0] ea;
    logic [CB-1:0] ed_a, ed_b;
    @(negedge clk);
    req = r; frame = f; addr = av;
    #1;
    hold = m_locked && r[m_owner];
    if (hold) gi = m_owner;
    else      gi = pick(r, m_locked ? (m_owner + 1) % N : m_ptr);
    eg = '0; ea = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ea = av[gi*AW +: AW];
    end
    ev_a = hist_g[0];
    ed_a = (ev_a != 0) ? rom_word(hist_a[0]) : '0;
    ev_b = hist_g[2];
    ed_b = (ev_b != 0) ? rom_word(hist_a[2]) : '0;

    check("grant_a",    if_a.grant,    eg);
    check("rom_addr_a", if_a.rom_addr, ea);
    check("rom_en_a",   if_a.rom_en,   eg != 0);
    check("busy_a",     busy_a,        m_locked || eg != 0);
    check("owner_a",    owner_a,       m_owner);
    check("conflict_a", conflict_a,    m_conf);
    check("cnt_a",      cnt_a,         m_cnt_a);
    check("rd_valid_a", if_a.rd_valid, ev_a);
    check("rd_data_a",  if_a.rd_data,  ed_a);
    check("grant_b",    if_b.grant,    eg);
    check("rom_addr_b", if_b.rom_addr, ea);
    check("owner_b",    owner_b,       m_owner);
    check("conflict_b", conflict_b,    m_conf);
    check("cnt_b",      cnt_b,         m_cnt_b);
    check("rd_valid_b", if_b.rd_valid, ev_b);
    check("rd_data_b",  if_b.rd_data,  ed_b);

    obs_grant_a = if_a.grant;
    obs_rdv_a   = if_a.rd_valid;
    obs_rdv_b   = if_b.rd_valid;
    obs_cnt_a   = cnt_a;
    obs_cnt_b   = cnt_b;
    obs_conf_a  = conflict_a;
    obs_conf_b  = conflict_b;

    if (!hold) begin
      if (m_locked) m_ptr = (m_owner + 1) % N;
      if (gi >= 0) begin
        m_locked = 1;
        m_owner  = gi;
      end else begin
        m_locked = 0;
      end
    end
    deny = (r & ~eg) != 0;
    if (f) begin
      m_cnt_a = 0; m_cnt_b = 0; m_conf = 0;
    end else if (deny) begin
      m_conf = 1;
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 15)    m_cnt_b++;
    end
    hist_g.push_front(eg); void'(hist_g.pop_back());
    hist_a.push_front(ea); void'(hist_a.pop_back());
  endtask

  // Reset asserted between clock edges while whatever request is in flight
  // stays applied; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_grant_a",    if_a.grant,    '0);
    check("rst_rom_en_a",   if_a.rom_en,   1'b0);
    check("rst_rd_valid_a", if_a.rd_valid, '0);
    check("rst_owner_a",    owner_a,       '0);
    check("rst_grant_b",    if_b.grant,    '0);
    check("rst_rd_valid_b", if_b.rd_valid, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    req = '0; frame = 1'b0; rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         frm;
    logic [N-1:0] exp_grant;
    int           exp_cnt;
    logic         exp_conf;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*AW-1:0] av;
    logic [N-1:0]    rs;
    int cnt16_a, cnt16_b, first_a, first_b;

    // Hand-derived sequence from reset: simultaneous requests, same-cycle
    // handoff, round-robin after a release, frame clear in a conflict cycle.
    tbl[0]  = '{4'b0011, 1'b0, 4'b0001, 0, 1'b0};
    tbl[1]  = '{4'b0011, 1'b0, 4'b0001, 1, 1'b1};
    tbl[2]  = '{4'b0011, 1'b0, 4'b0001, 2, 1'b1};
    tbl[3]  = '{4'b0010, 1'b0, 4'b0010, 3, 1'b1};
    tbl[4]  = '{4'b0010, 1'b0, 4'b0010, 3, 1'b1};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 3, 1'b1};
    tbl[6]  = '{4'b1000, 1'b0, 4'b1000, 3, 1'b1};
    tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 3, 1'b1};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0001, 3, 1'b1};
    tbl[9]  = '{4'b1001, 1'b0, 4'b0001, 3, 1'b1};
    tbl[10] = '{4'b1001, 1'b0, 4'b0001, 4, 1'b1};
    tbl[11] = '{4'b1000, 1'b0, 4'b1000, 5, 1'b1};
    tbl[12] = '{4'b1100, 1'b0, 4'b1000, 5, 1'b1};
    tbl[13] = '{4'b0100, 1'b1, 4'b0100, 6, 1'b1};
    tbl[14] = '{4'b0110, 1'b0, 4'b0100, 0, 1'b0};
    tbl[15] = '{4'b0110, 1'b1, 4'b0100, 1, 1'b1};
    tbl[16] = '{4'b0010, 1'b0, 4'b0010, 0, 1'b0};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0};

    req = '0; frame = 1'b0; addr = '0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    req = 4'b1111;
    #1;
    check("rst_hold_grant_a",  if_a.grant,  '0);
    check("rst_hold_rom_en_a", if_a.rom_en, 1'b0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    av = {10'd53, 10'd37, 10'd21, 10'd5};
    for (int v = 0; v < 18; v++) begin
      step(tbl[v].req, tbl[v].frm, av);
      check($sformatf("tbl%0d_grant", v), obs_grant_a, tbl[v].exp_grant);
      check($sformatf("tbl%0d_cnt", v),   obs_cnt_a,   tbl[v].exp_cnt);
      check($sformatf("tbl%0d_conf", v),  obs_conf_a,  tbl[v].exp_conf);
    end

    // Single requester: engine 2 over a 16-pixel run at 0x040..0x04F.
    step('0, 1'b1, av);
    cnt16_a = 0; cnt16_b = 0; first_a = -1; first_b = -1;
    for (int j = 0; j < 20; j++) begin
      av = {$urandom, $urandom};
      av[2*AW +: AW] = 10'h040 + 10'(j);
      step((j < 16) ? 4'b0100 : 4'b0000, 1'b0, av);
      if (obs_rdv_a == 4'b0100) begin
        cnt16_a++;
        if (first_a < 0) first_a = j;
      end
      if (obs_rdv_b == 4'b0100) begin
        cnt16_b++;
        if (first_b < 0) first_b = j;
      end
    end
    check("run_valid_cycles_a", cnt16_a, 16);
    check("run_valid_cycles_b", cnt16_b, 16);
    check("run_lag_a", first_a, 1);
    check("run_lag_b", first_b, 3);
    check("run_cnt_a", obs_cnt_a, 0);

    // Saturation of the 4-bit counter, then a frame pulse in a conflict cycle.
    step('0, 1'b1, av);
    for (int j = 0; j < 20; j++) step(4'b0011, 1'b0, av);
    check("sat_cnt_b", obs_cnt_b, 15);
    check("sat_cnt_a", obs_cnt_a, 19);
    step(4'b0011, 1'b1, av);
    step(4'b0011, 1'b0, av);
    check("clr_cnt_b",  obs_cnt_b,  0);
    check("clr_conf_b", obs_conf_b, 1'b0);
    step(4'b0011, 1'b0, av);
    check("resume_cnt_b",  obs_cnt_b,  1);
    check("resume_conf_b", obs_conf_b, 1'b1);

    // Reset while engine 1 holds the ROM.
    step(4'b0010, 1'b0, av);
    step(4'b0010, 1'b0, av);
    check("pre_rst_owner_a", owner_a, 1);
    async_reset();
    step(4'b0110, 1'b0, av);
    check("post_rst_grant_a", obs_grant_a, 4'b0010);

    // Randomised runs: requests toggle rarely so runs last several cycles.
    rs = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rs[i] = ~rs[i];
      av = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) async_reset();
      step(rs, ($urandom_range(0, 63) == 0), av);
    end
    repeat (4) step('0, 1'b0, av);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite graphics ROM read port among NREQ sprite engines (alien rows, player, shots).
- Each engine raises req for the whole horizontal run of a sprite line and presents its pixel address every cycle.
- The arbiter locks the ROM to one engine per run, returns read data with fixed latency, and counts denied cycles per frame for debug.
- Sits between the sprite engines and the shared graphics BRAM in the video pipeline.

Parameters:
NREQ, 4, number of requesting sprite engines (2..8)
ADDRW, 10, ROM address width
COLR_BITS, 4, bits per pixel of ROM data
LAT, 1, ROM read latency in cycles (1..4)
CNTW, 16, width of conflict counter

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-high reset
frame  input  1  start-of-frame pulse; clears conflict statistics
req  input  NREQ  per-engine request; held high for the whole run
addr  input  NREQ*ADDRW  packed per-engine ROM address; slice i = addr[i*ADDRW +: ADDRW]
grant  output  NREQ  one-hot grant; at most one bit set
rom_addr  output  ADDRW  address to shared ROM
rom_en  output  1  ROM read enable
rom_data  input  COLR_BITS  ROM read data, valid LAT cycles after rom_en
rd_data  output  COLR_BITS  rom_data when any rd_valid bit is set, else 0
rd_valid  output  NREQ  one-hot marker of which engine rd_data belongs to
owner  output  $clog2(NREQ)  index of the current or last owner; 0 after reset
busy  output  1  grant currently held
conflict  output  1  sticky: some request was denied since last frame/reset
conflict_cnt  output  CNTW  denied-request cycles since last frame, saturating

Behaviour:
- States: IDLE (no owner) and LOCKED (owner holds ROM).
- Arbitration runs in IDLE and in the release cycle of LOCKED.
  - Winner = first i with req[i]=1, scanning cyclically from rr_ptr.
  - Combinational same cycle: grant[winner]=1, rom_addr=addr slice winner, rom_en=1.
  - Next state LOCKED, owner<=winner.
- LOCKED with req[owner]=1:
  - grant[owner]=1, rom_addr follows the owner's slice every cycle, rom_en=1.
  - Other requesters are denied regardless of index.
- LOCKED with req[owner]=0 (release cycle):
  - rr_ptr<=(owner+1) mod NREQ.
  - Same-cycle arbitration among remaining requesters uses the new pointer (back-to-back handoff, no bubble).
  - If none are requesting: go to IDLE with grant=0, rom_en=0.
- In IDLE with no req: grant=0, rom_en=0, rom_addr=0.
- Return pipeline:
  - LAT-stage shift register of grant (one-hot) aligned to ROM latency.
  - rd_valid = last stage; rd_data = rom_data when rd_valid!=0, else 0.
  - Pipeline runs freely; no stalls.
- busy = (state==LOCKED) or any grant this cycle.
- Conflict counting:
  - Any cycle where (req & ~grant)!=0: conflict_cnt += 1 (saturates at 2^CNTW-1) and conflict<=1.
  - frame=1 clears both; clear wins over a same-cycle increment, result 0.
- Reset (async, any time, including mid-run):
  - state IDLE, owner 0, rr_ptr 0, pipeline cleared, conflict 0, conflict_cnt 0.
  - grant, rom_en and rd_valid go 0 immediately.
  - After reset deassertion, arbitration resumes from pointer 0.
- All arithmetic is unsigned. rr_ptr and owner wrap modulo NREQ, with NREQ not necessarily a power of 2.

Test Plan:
- Single requester: req[2]=1 for 16 cycles, addr[2]=0x040..0x04F.
  - Required: grant=4'b0100 same cycle, rom_addr tracks addr.
  - Required: rd_valid=4'b0100 exactly 16 cycles starting LAT later; rd_data equals ROM content; conflict_cnt=0.
- Simultaneous req=4'b0011 from reset.
  - Required: engine 0 wins; engine 1 is denied each cycle and conflict_cnt counts those cycles, conflict=1.
  - Required: when req[0] falls, grant=4'b0010 in that same cycle.
- Round-robin: owner 3 releases with req=4'b1001 (engine 3 re-requests next cycle).
  - Required: engine 0 is granted on release, not engine 3; rr_ptr=0.
  - Required: after engine 0 releases, engine 3 wins.
- LAT=3 build with 8-cycle run.
  - Required: rd_valid lags grant by exactly 3 cycles; rd_data=0 outside the valid window.
- Saturation/clear with CNTW=4: hold a denied request for 20 cycles.
  - Required: conflict_cnt sticks at 15.
  - Required: frame pulse in a conflicting cycle gives conflict_cnt=0 and conflict=0, then counting resumes at 1.
- Reset mid-run: assert rst while owner=1 is LOCKED.
  - Required: grant, rom_en and rd_valid are 0 asynchronously, owner=0.
  - Required: after release, req=4'b0110 grants engine 1.
